// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file geometry and named register indices
// used by both the write-back select logic and the register file.
package cpu_pkg;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned WORD_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;
endpackage

// File: rtl/regfile_decode_decoder.sv
// 5-to-32 one-hot decoder with enable; purely combinational.
module decoder_5to32
  import cpu_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic                  en,
  output logic [NUM_REGS-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_decode.sv
// 32-entry register file with one decoded write port, two combinational
// read ports, hardwired zero register and optional write-through bypass.
module regfile_decode
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH  = WORD_W,
  parameter int unsigned BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr0,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  output logic [WIDTH-1:0]      rd_data0,
  output logic [WIDTH-1:0]      rd_data1
);

  logic [NUM_REGS-1:0] wr_onehot;
  logic [WIDTH-1:0]    regs_q [1:NUM_REGS-1];
  logic [WIDTH-1:0]    regs_d [1:NUM_REGS-1];

  decoder_5to32 u_decoder (
    .addr   (wr_addr),
    .en     (wr_en),
    .onehot (wr_onehot)
  );

  // Register 0 has no storage, so its enable bit is never consumed here.
  always_comb begin
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (reset)             regs_d[i] = '0;
      else if (wr_onehot[i]) regs_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 1; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
  end

  // wr_onehot[rd_addrN] is exactly "wr_en && wr_addr == rd_addrN".
  always_comb begin
    rd_data0 = '0;
    if (rd_addr0 != REG_ZERO) begin
      if (BYPASS != 0 && wr_onehot[rd_addr0]) rd_data0 = wr_data;
      else                                   rd_data0 = regs_q[rd_addr0];
    end
  end

  always_comb begin
    rd_data1 = '0;
    if (rd_addr1 != REG_ZERO) begin
      if (BYPASS != 0 && wr_onehot[rd_addr1]) rd_data1 = wr_data;
      else                                   rd_data1 = regs_q[rd_addr1];
    end
  end

endmodule
